// File: rtl/key_event_uart_tx.sv
// Event FIFO feeding an 8N1 UART transmitter.
// Key/encoder events queue here and drain to the host MCU one frame at a time.
module key_event_uart_tx #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  input  logic [7:0]        ev_code,
  input  logic              ovf_clr,
  output logic              uart_tx,
  output logic [ADDR_W:0]   fifo_count,
  output logic              irq,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [2:0]        bitIdx, bitIdxNext;
  logic [7:0]        shiftReg, shiftNext;
  logic              txNext;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   countNext;
  logic              bitEnd, notEmpty, full;
  logic              pop, push, drop;

  assign bitEnd   = (cnt == CNT_LAST);
  assign notEmpty = (fifo_count != '0);
  assign full     = (fifo_count == FULL_CNT);

  always_comb begin
    stateNext  = state;
    cntNext    = bitEnd ? '0 : cnt + 1'b1;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    txNext     = uart_tx;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        txNext  = 1'b1;
        cntNext = '0;
        if (notEmpty) begin
          pop       = 1'b1;
          txNext    = 1'b0;
          stateNext = START;
        end
      end
      START: begin
        if (bitEnd) begin
          txNext     = shiftReg[0];
          bitIdxNext = '0;
          stateNext  = DATA;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx != 3'd7) begin
            shiftNext  = shiftReg >> 1;
            bitIdxNext = bitIdx + 3'd1;
            txNext     = shiftReg[1];
          end else begin
            txNext    = 1'b1;
            stateNext = STOP;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (notEmpty) begin
            pop       = 1'b1;
            txNext    = 1'b0;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (pop) shiftNext = mem[rdPtr];
  end

  // A full FIFO still accepts an event when the head leaves on the same edge
  assign push = ev_valid & (~full | pop);
  assign drop = ev_valid & full & ~pop;

  always_comb begin
    countNext = fifo_count;
    if (push & ~pop) countNext = fifo_count + 1'b1;
    if (pop & ~push) countNext = fifo_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= ev_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      uart_tx    <= 1'b1;
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftNext;
      uart_tx    <= txNext;
      fifo_count <= countNext;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      irq  <= (countNext != '0) | (stateNext != IDLE);
      busy <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_uart_tx.sv
// Bench for key_event_uart_tx: frame-timeline reference model,
// per-cycle output compare, and directed plus random stimulus.
module tb_key_event_uart_tx;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0;
  logic [7:0] ev_code = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       uart_tx;
  logic [3:0] fifo_count;
  logic       irq, overflow, busy;

  int checks = 0;
  int failures = 0;

  key_event_uart_tx #(
    .DEPTH(DEPTH), .ADDR_W(3), .CLKS_PER_BIT(CPB), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_code(ev_code),
    .ovf_clr(ovf_clr), .uart_tx(uart_tx), .fifo_count(fifo_count),
    .irq(irq), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a queue of pending codes plus the position inside the
  // frame currently on the line.
  logic [7:0] q[$];
  bit         mActive = 0;
  int         mPos = 0;
  logic [7:0] mByte = 8'h00;
  bit         mOvf = 0;

  function automatic logic lineAt(int pos, logic [7:0] b);
    if (pos < CPB) return 1'b0;
    if (pos < 9 * CPB) return b[pos / CPB - 1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mActive = 0;
      mPos = 0;
      mOvf = 0;
    end else begin
      automatic int  sz = q.size();
      automatic bit  frameEnd = mActive && (mPos == FRAME - 1);
      automatic bit  doPop = (sz != 0) && (!mActive || frameEnd);
      automatic bit  doPush = ev_valid && (sz < DEPTH || doPop);
      automatic bit  doDrop = ev_valid && !doPush;
      if (doPop) mByte = q.pop_front();
      if (doPush) q.push_back(ev_code);
      if (doPop) begin
        mActive = 1;
        mPos = 0;
      end else if (frameEnd) begin
        mActive = 0;
      end else if (mActive) begin
        mPos++;
      end
      if (doDrop) mOvf = 1;
      else if (ovf_clr) mOvf = 0;
    end
  end

  bit trackMax = 0;
  int maxCnt = 0;

  always @(negedge clk) begin
    chk("uart_tx", uart_tx, mActive ? lineAt(mPos, mByte) : 1'b1);
    chk("fifo_count", fifo_count, q.size());
    chk("busy", busy, mActive);
    chk("irq", irq, (q.size() != 0) || mActive);
    chk("overflow", overflow, mOvf);
    if (trackMax && int'(fifo_count) > maxCnt) maxCnt = fifo_count;
  end

  task automatic pulse(logic [7:0] c);
    @(negedge clk);
    ev_valid = 1'b1;
    ev_code  = c;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((busy || fifo_count != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < lim, 1);
  endtask

  logic [39:0] frame81 =
    40'b0000_1111_0000_0000_0000_0000_0000_0000_1111_1111;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame, literal waveform
    pulse(8'h81);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("frame81_bit%0d", i), uart_tx, frame81[39-i]);
    end
    @(negedge clk);
    chk("frame81_busy_after", busy, 0);
    chk("frame81_irq_after", irq, 0);

    // burst of 10: ninth fills the FIFO, tenth is dropped
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ev_valid = 1'b1;
      ev_code  = 8'(k);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    chk("burst_count_full", fifo_count, 8);
    chk("burst_overflow", overflow, 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    drain(1000);

    // full FIFO with an event on the STOP pop edge (edge 42)
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ev_valid = 1'b1;
      ev_code  = 8'(8'h10 + k);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    chk("fill_count", fifo_count, 8);
    repeat (32) @(negedge clk);
    ev_valid = 1'b1;
    ev_code  = 8'hAA;
    @(negedge clk);
    ev_valid = 1'b0;
    chk("pop_push_count", fifo_count, 8);
    chk("pop_push_no_ovf", overflow, 0);
    ev_valid = 1'b1;
    ev_code  = 8'hBB;
    ovf_clr  = 1'b1;
    @(negedge clk);
    ev_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("drop_beats_clear", overflow, 1);
    drain(1000);

    // reset during data bit 3 with three events queued
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ev_valid = 1'b1;
      ev_code  = 8'(8'h30 + k);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_bit3", uart_tx, 0);
    chk("pre_rst_count", fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_uart_tx", uart_tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse(8'h5A);
    drain(200);

    // wrap-around stream spaced one frame apart
    trackMax = 1;
    for (int k = 0; k < 20; k++) begin
      pulse(8'($urandom));
      repeat (FRAME + 4) @(negedge clk);
    end
    trackMax = 0;
    chk("wrap_max_count_le2", maxCnt <= 2, 1);

    // random traffic: light then heavy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ev_valid = ($urandom_range(99) < ((i < 1500) ? 2 : 9));
      ev_code  = 8'($urandom);
      ovf_clr  = ($urandom_range(99) < 1);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    ovf_clr  = 1'b0;
    drain(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
